efpga_accel_responder: RTL
==========================

// Module: efpga_accel_responder
// PURPOSE
//  Fabric-side responder for the core's eFPGA custom-instruction interface. Accepts a start
//  pulse with a 2-bit operator and two 32-bit operands, runs an iterative unsigned multiply
//  or multiply-accumulate, or commits a write to its accumulator register. Presents three
//  result buses plus a one-cycle done pulse that the core samples in done-driven mode.
// PARAMETERS
//  BITS_PER_CYCLE  1      multiplier bits retired per cycle; legal values 1,2,4,8
//  ACC_RESET       32'h0  accumulator value after reset
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   synchronous, active-low reset
//  start_i        in   1   1-cycle request; same cycle the core's enable is asserted
//  operator_i     in   2   00 mul-lo, 01 mul-hi, 10 MAC, 11 acc write; stable start..done
//  operand_a_i    in   32  multiplicand / write data; stable start..done
//  operand_b_i    in   32  multiplier; stable start..done
//  write_strobe_i in   1   core write strobe; high from start+1 until core capture
//  result_a_o     out  32  product[31:0] (00/01/10); previous acc (11)
//  result_b_o     out  32  product[63:32] (00/01/10)
//  result_c_o     out  32  accumulator after MAC (10 only)
//  done_o         out  1   single-cycle completion pulse
//  busy_o         out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Reset: FSM IDLE; result_a/b/c_o=0; done_o=0; busy_o=0; acc=ACC_RESET; step counter=0.
//  - STEPS = 32/BITS_PER_CYCLE.
//  - FSM states IDLE, MUL, WR, DONE:
//    IDLE: start_i & op!=11 -> MUL; latch a,b; product=0; count=0.
//          start_i & op==11 -> WR. No start_i -> stay.
//    MUL:  each cycle product += (a * b[BPC-1:0]) << (count*BPC); b >>= BPC; count++.
//          After STEPS cycles -> DONE; write result_a=prod[31:0], result_b=prod[63:32];
//          op 10 additionally acc <= acc + prod[31:0] (mod 2^32), result_c <= new acc.
//    WR:   wait for write_strobe_i==1; then result_a <= acc, acc <= operand_a_i, -> DONE.
//          Strobe never arriving: remain in WR (only reset exits).
//    DONE: done_o=1 for exactly this cycle -> IDLE.
//  - Latency: op 00/01/10 done_o in cycle start+1+STEPS (start+33 with BPC=1);
//    op 11 done_o in cycle start+2 with the core's strobe timing (strobe at start+1).
//    Core fixed-delay mode must program delay >= latency-1; done mode needs no setting.
//  - Results registered; stable from done_o cycle until next completion overwrites them.
//    Outputs not written by an operation keep their value (e.g. op 11 leaves b,c).
//  - Product arithmetic 64-bit unsigned, no overflow; accumulator wraps mod 2^32.
//  - start_i while busy_o=1 (including DONE cycle): ignored, no state or output change.
//  - Operator 01 and 00 compute identically; the core selects the bus.
//  - Reset mid-operation: abort to IDLE, no done_o pulse, all outputs/acc to reset values.
//  - write_strobe_i outside WR: ignored.
// TESTING
//  1. Reset held 2 cycles, release -> result_a/b/c=0, done_o=0, busy_o=0, acc=0.
//  2. op00 a=FFFF_FFFF b=2, BPC=1 -> done_o only at start+33; result_a=FFFF_FFFE, result_b=1.
//  3. op10 a=3 b=5 twice back-to-back -> result_c=15 then 30; one done pulse each.
//  4. op11 a=0000_0100, strobe at start+1 -> done at start+2, result_a=0; then op10 a=1 b=1
//     -> result_c=0000_0101.
//  5. start_i pulsed at start+5 of an op00 -> ignored, single done at start+33, results of
//     first op; rst_n low at start+10 of op00 -> IDLE, no done, outputs 0.
//  6. BPC=4 op00 a=1234_5678 b=9ABC_DEF0 -> done at start+9; {b,a}=0B00_EA4E_242D_2080.

Source files
------------

// File: rtl/efpga_accel_responder.sv
// rtl/efpga_accel_responder.sv - eFPGA custom-instruction responder: iterative multiply, MAC and accumulator write
module efpga_accel_responder #(
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [31:0] ACC_RESET      = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  operator_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        write_strobe_i,
    output logic [31:0] result_a_o,
    output logic [31:0] result_b_o,
    output logic [31:0] result_c_o,
    output logic        done_o,
    output logic        busy_o
);

    localparam int          STEPS = 32 / BITS_PER_CYCLE;
    localparam logic [5:0]  LAST  = 6'(STEPS - 1);
    localparam logic [5:0]  BPC6  = 6'(BITS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, MUL, WR, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] acc;
    logic [63:0] product;
    logic [63:0] partial;
    logic [63:0] product_sum;
    logic [31:0] acc_sum;
    logic [5:0]  count;
    logic [5:0]  shift;
    logic        mac;

    // One radix-2^BPC digit of the multiplier per cycle, weighted by its position.
    always_comb begin
        shift       = count * BPC6;
        partial     = ({32'b0, a_reg} * {{(64 - BITS_PER_CYCLE){1'b0}}, b_reg[BITS_PER_CYCLE-1:0]}) << shift;
        product_sum = product + partial;
        acc_sum     = acc + product_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (operator_i == 2'b11) ? WR : MUL;
                end
            end
            MUL: begin
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            WR: begin
                if (write_strobe_i) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= 32'h0;
            b_reg      <= 32'h0;
            product    <= 64'h0;
            count      <= 6'd0;
            mac        <= 1'b0;
            acc        <= ACC_RESET;
            result_a_o <= 32'h0;
            result_b_o <= 32'h0;
            result_c_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && operator_i != 2'b11) begin
                        a_reg   <= operand_a_i;
                        b_reg   <= operand_b_i;
                        product <= 64'h0;
                        count   <= 6'd0;
                        mac     <= (operator_i == 2'b10);
                    end
                end
                MUL: begin
                    product <= product_sum;
                    b_reg   <= b_reg >> BITS_PER_CYCLE;
                    count   <= count + 6'd1;
                    if (count == LAST) begin
                        result_a_o <= product_sum[31:0];
                        result_b_o <= product_sum[63:32];
                        if (mac) begin
                            acc        <= acc_sum;
                            result_c_o <= acc_sum;
                        end
                    end
                end
                WR: begin
                    if (write_strobe_i) begin
                        result_a_o <= acc;
                        acc        <= operand_a_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_o = (state == DONE);
    assign busy_o = (state != IDLE);

endmodule
